// File: rtl/seg7_varredura.sv
// seg7_varredura: time-multiplexed N-digit 7-segment driver.
// Holds a shadow copy of the digit values and scans one anode at a time.
// Each digit slot starts with a short guard window, with all anodes off,
// so the previous digit's segments never bleed into the next digit.
// Decodes in decimal or hex, with optional leading-zero blanking.
// Outputs are registered: they follow the state sampled at each edge.

module seg7_varredura #(
  parameter int N_DIGITOS     = 4,
  parameter int CICLOS_DIGITO = 50000,
  parameter int CICLOS_GUARDA = 2,
  parameter bit ATIVO_BAIXO   = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*N_DIGITOS-1:0] entrada,
  input  logic                   carregar,
  input  logic                   modo_hex,
  input  logic                   apagar_zeros,
  input  logic                   habilita,
  output logic [6:0]             saida,
  output logic [N_DIGITOS-1:0]   anodo
);

  localparam int CW = (CICLOS_DIGITO > 1) ? $clog2(CICLOS_DIGITO) : 1;
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

  localparam logic [CW-1:0] CNT_MAX    = CW'(CICLOS_DIGITO - 1);
  localparam logic [CW-1:0] CNT_GUARDA = CW'(CICLOS_GUARDA);
  localparam logic [IW-1:0] IDX_MAX    = IW'(N_DIGITOS - 1);

  // Active-low reference patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;

  // "Off" level of the pins for the selected polarity
  localparam logic [6:0]           SEG_OFF = {7{ATIVO_BAIXO}};
  localparam logic [N_DIGITOS-1:0] AN_OFF  = {N_DIGITOS{ATIVO_BAIXO}};

  logic [4*N_DIGITOS-1:0] sombra;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;

  logic [3:0]             nibble;
  logic [N_DIGITOS-1:0]   zero_acima;
  logic                   apagado;
  logic [N_DIGITOS-1:0]   um_quente;
  logic [6:0]             seg_baixo;
  logic                   em_guarda;

  // Active-low pattern for one nibble; decimal mode shows 10..15 as a dash.
  function automatic logic [6:0] decodifica(input logic [3:0] v, input logic hex);
    logic [6:0] p;
    p = SEG_APAGADO;
    case (v)
      4'h0: p = 7'b1000000;
      4'h1: p = 7'b1111001;
      4'h2: p = 7'b0100100;
      4'h3: p = 7'b0110000;
      4'h4: p = 7'b0011001;
      4'h5: p = 7'b0010010;
      4'h6: p = 7'b0000010;
      4'h7: p = 7'b1111000;
      4'h8: p = 7'b0000000;
      4'h9: p = 7'b0011000;
      4'hA: p = hex ? 7'b0001000 : SEG_TRACO;
      4'hB: p = hex ? 7'b0000011 : SEG_TRACO;
      4'hC: p = hex ? 7'b1000110 : SEG_TRACO;
      4'hD: p = hex ? 7'b0100001 : SEG_TRACO;
      4'hE: p = hex ? 7'b0000110 : SEG_TRACO;
      4'hF: p = hex ? 7'b0001110 : SEG_TRACO;
      default: p = SEG_APAGADO;
    endcase
    return p;
  endfunction

  // Shadow register: loads on carregar regardless of habilita or scan position
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sombra <= '0;
    end else if (carregar) begin
      sombra <= entrada;
    end
  end

  // Slot counter and digit index; both freeze while habilita is low
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (habilita) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Nibble, one-hot anode and zero-above flags for the current index.
  // zero_acima[i] is set when nibble i and every higher nibble are zero.
  always_comb begin
    logic tudo_zero;
    nibble     = '0;
    um_quente  = '0;
    zero_acima = '0;
    apagado    = 1'b0;
    tudo_zero  = 1'b1;
    for (int i = N_DIGITOS - 1; i >= 0; i--) begin
      tudo_zero     = tudo_zero & (sombra[4*i +: 4] == 4'h0);
      zero_acima[i] = tudo_zero;
    end
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (idx == IW'(i)) begin
        nibble       = sombra[4*i +: 4];
        um_quente[i] = 1'b1;
        // Digit 0 always shows something, so a zero value reads "0"
        if (i > 0) begin
          apagado = apagar_zeros & zero_acima[i];
        end
      end
    end
  end

  // Segment pattern and guard decision for this cycle
  always_comb begin
    seg_baixo = apagado ? SEG_APAGADO : decodifica(nibble, modo_hex);
    em_guarda = !habilita || (cnt < CNT_GUARDA);
  end

  // Registered pin drivers; polarity applied at the last stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida <= SEG_OFF;
      anodo <= AN_OFF;
    end else if (em_guarda) begin
      saida <= SEG_OFF;
      anodo <= AN_OFF;
    end else if (ATIVO_BAIXO) begin
      saida <= seg_baixo;
      anodo <= ~um_quente;
    end else begin
      saida <= ~seg_baixo;
      anodo <= um_quente;
    end
  end

endmodule

// File: tb/tb_seg7_varredura.sv
// Bench for seg7_varredura: N=4, 4-cycle slots, 1-cycle guard.
// Two instances share the inputs: one active-low, one active-high.
// Stimulus pushes the expected pins for each edge; a monitor pops and checks.

module tb_seg7_varredura;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] entrada;
  logic        carregar;
  logic        modo_hex;
  logic        apagar_zeros;
  logic        habilita;
  logic [6:0]  saida, saida_ah;
  logic [3:0]  anodo, anodo_ah;

  localparam logic [6:0] BR = 7'b1111111;
  localparam logic [6:0] TR = 7'b0111111;

  logic [6:0] tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    string      nome;
  } esperado_t;

  esperado_t fila[$];
  int total = 0;
  int bad   = 0;
  int cur   = 0;

  always #5 clock = ~clock;

  seg7_varredura #(
    .N_DIGITOS(4), .CICLOS_DIGITO(4), .CICLOS_GUARDA(1), .ATIVO_BAIXO(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .entrada(entrada), .carregar(carregar),
    .modo_hex(modo_hex), .apagar_zeros(apagar_zeros), .habilita(habilita),
    .saida(saida), .anodo(anodo)
  );

  seg7_varredura #(
    .N_DIGITOS(4), .CICLOS_DIGITO(4), .CICLOS_GUARDA(1), .ATIVO_BAIXO(1'b0)
  ) dut_ah (
    .clock(clock), .reset(reset), .entrada(entrada), .carregar(carregar),
    .modo_hex(modo_hex), .apagar_zeros(apagar_zeros), .habilita(habilita),
    .saida(saida_ah), .anodo(anodo_ah)
  );

  // Compare both instances against an active-low expectation
  task automatic confere(input string nome, input logic [6:0] eseg, input logic [3:0] ean);
    total++;
    if (saida !== eseg || anodo !== ean) begin
      bad++;
      $display("FAIL %s (baixo): saida=%b anodo=%b, esperado saida=%b anodo=%b",
               nome, saida, anodo, eseg, ean);
    end
    total++;
    if (saida_ah !== ~eseg || anodo_ah !== ~ean) begin
      bad++;
      $display("FAIL %s (alto): saida=%b anodo=%b, esperado saida=%b anodo=%b",
               nome, saida_ah, anodo_ah, ~eseg, ~ean);
    end
  endtask

  // Monitor: every edge's result is checked mid-cycle
  initial begin
    esperado_t e;
    forever begin
      @(negedge clock);
      if (fila.size() > 0) begin
        e = fila.pop_front();
        confere(e.nome, e.seg, e.an);
      end
    end
  end

  task automatic ciclo(input logic [3:0] an, input logic [6:0] seg, input string nome);
    esperado_t e;
    e.an = an; e.seg = seg; e.nome = nome;
    fila.push_back(e);
    @(negedge clock); #1;
  endtask

  task automatic desligado(input string nome);
    ciclo(4'hF, BR, nome);
  endtask

  function automatic logic [3:0] an_de(input int d);
    logic [3:0] a;
    a = 4'b0001 << d;
    return ~a;
  endfunction

  // One full slot of the current digit: guard cycle then three lit cycles
  task automatic slot(input logic [6:0] seg, input string nome);
    desligado({nome, "_guarda"});
    repeat (3) ciclo(an_de(cur), seg, nome);
    cur = (cur + 1) % 4;
  endtask

  // Four slots starting at the current digit; sN is the pattern of digit N
  task automatic quadro(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input string nome);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    repeat (4) slot(s[cur], nome);
  endtask

  // Load at a slot boundary with the scan paused for one edge
  task automatic carrega(input logic [15:0] v);
    habilita = 1'b0;
    entrada  = v;
    carregar = 1'b1;
    desligado("carga");
    carregar = 1'b0;
    habilita = 1'b1;
  endtask

  initial begin
    reset = 1'b1; entrada = '0; carregar = 1'b0;
    modo_hex = 1'b0; apagar_zeros = 1'b0; habilita = 1'b0;
    @(negedge clock); #1;
    desligado("reset");
    reset = 1'b0;

    // Basic scan of 0x1234 and wrap back to digit 0
    carrega(16'h1234);
    quadro(tab[4], tab[3], tab[2], tab[1], "varre_1234");
    slot(tab[4], "volta_dig0");

    // Decimal vs hex decode of 0x00AF
    carrega(16'h00AF);
    quadro(TR, TR, tab[0], tab[0], "dec_00af");
    modo_hex = 1'b1;
    quadro(tab[15], tab[10], tab[0], tab[0], "hex_00af");
    modo_hex = 1'b0;

    // Leading-zero blanking
    apagar_zeros = 1'b1;
    carrega(16'h0070);
    quadro(tab[0], tab[7], BR, BR, "lz_0070");
    carrega(16'h0000);
    quadro(tab[0], BR, BR, BR, "lz_0000");
    carrega(16'h0102);
    quadro(tab[2], tab[0], tab[1], BR, "lz_0102");
    carrega(16'h0008);
    quadro(tab[8], BR, BR, BR, "lz_0008");
    apagar_zeros = 1'b0;

    // Pause mid-slot: counter held at 2, slot finishes after resume
    carrega(16'h1234);
    desligado("pausa_guarda");
    ciclo(an_de(cur), tab[4-cur], "pausa_antes");
    habilita = 1'b0;
    repeat (10) desligado("pausa");
    habilita = 1'b1;
    ciclo(an_de(cur), tab[4-cur], "pausa_retoma");
    ciclo(an_de(cur), tab[4-cur], "pausa_retoma");
    cur = (cur + 1) % 4;
    slot(tab[4-cur], "pausa_prox");

    // entrada without carregar is ignored; a mid-slot load shows one edge later
    desligado("meio_guarda");
    entrada = 16'h5678;
    ciclo(an_de(cur), tab[4-cur], "sem_carga");
    carregar = 1'b1;
    ciclo(an_de(cur), tab[4-cur], "carga_meio");
    carregar = 1'b0;
    ciclo(an_de(cur), tab[8-cur], "carga_vista");
    cur = (cur + 1) % 4;
    slot(tab[8-cur], "apos_carga");

    // Async reset between edges, mid-slot
    desligado("rst_guarda");
    ciclo(an_de(cur), tab[8-cur], "rst_antes");
    #1 reset = 1'b1;
    #1 confere("reset_async", BR, 4'hF);
    #1 reset = 1'b0;
    cur = 0;
    quadro(tab[0], tab[0], tab[0], tab[0], "pos_reset");

    @(negedge clock); #1;
    total++;
    if (fila.size() != 0) begin
      bad++;
      $display("FAIL fila_vazia: restam=%0d, esperado=0", fila.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_varredura.md
Name: seg7_varredura

Overview:
- Time-multiplexed driver for an N-digit 7-segment display on a shared segment bus, one anode line per digit.
- Holds a double-buffered copy of the digit values.
- Scans the digits at a programmable rate, with guard time between digits to prevent ghosting.
- Decodes in decimal or hex mode, with optional leading-zero blanking.
- Sits between the counters/datapath and the board display pins; replaces the per-digit combinational decoders.

Parameters:
- N_DIGITOS, 4, number of digits; range 1..8.
- CICLOS_DIGITO, 50000, clock cycles each digit slot lasts; must be >= 2.
- CICLOS_GUARDA, 2, cycles at the start of each slot with all anodes off; must be < CICLOS_DIGITO.
- ATIVO_BAIXO, 1, 1 = segments and anodes active-low; 0 = both active-high.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous reset, active-high
- entrada  input  4*N_DIGITOS  digit values; nibble i = digit i, digit 0 least significant
- carregar  input  1  load strobe; captures entrada into the shadow register
- modo_hex  input  1  1 = hex decode, 0 = decimal decode
- apagar_zeros  input  1  1 = blank leading zeros
- habilita  input  1  0 = display dark and scan frozen
- saida  output  7  segments {g,f,e,d,c,b,a}, bit 0 = a
- anodo  output  N_DIGITOS  per-digit enable, bit i = digit i

Behaviour:
- Reset (async, active-high):
  - shadow register = 0, digit index = 0, slot counter = 0.
  - saida and anodo at the "off" level: all 1 when ATIVO_BAIXO=1, all 0 otherwise.
- Load:
  - On a rising edge with carregar=1, the shadow register takes entrada.
  - entrada is ignored otherwise; decoding always uses the shadow register.
- Slot counter:
  - Counts 0..CICLOS_DIGITO-1 while habilita=1, then wraps to 0.
  - On the wrap edge, the index advances by 1 and wraps from N_DIGITOS-1 to 0.
  - habilita=0 holds the counter and index; they resume from the held values.
- Outputs are registered and update on the edge after their inputs change. Per cycle:
  - Guard: if habilita=0 or counter < CICLOS_GUARDA, both outputs go to the off level.
  - Otherwise, anodo is one-hot on the current index.
  - Otherwise, saida = decode(nibble[index]).
- Decode, active-low patterns {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001.
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0011000.
  - Hex mode adds A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - Decimal mode maps values 10..15 to dash 0111111.
  - Blank = 1111111.
  - ATIVO_BAIXO=0 inverts saida and anodo bitwise.
- Leading-zero blanking:
  - With apagar_zeros=1, digit i (i > 0) is blanked when nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - A blanked digit still drives its anode; only the segments are blank.
- Latency:
  - A carregar edge is visible on saida one edge later, if the index points at the changed digit and the slot is outside guard time.
- Simultaneous events:
  - carregar during a slot updates the current digit mid-slot; no wait for the slot boundary.
  - carregar together with habilita=0 still loads.
  - Mode and blanking inputs are sampled every cycle, with no buffering.
- Reset mid-scan: all state returns to reset values immediately; scanning restarts at digit 0, counter 0, with the guard time applied.

Test Plan:
- Reset, then N_DIGITOS=4, CICLOS_DIGITO=4, CICLOS_GUARDA=1, entrada=0x1234, carregar pulse, habilita=1 -> per 4-cycle slot: 1 cycle anodo=1111, then 3 cycles with anodo=1110 and saida=0011001 ("4"). Next slot: anodo=1101, saida=0110000. Index wraps after digit 3 back to anodo=1110.
- Shadow=0x00AF, modo_hex=0 -> digits 0 and 1 show 0111111. With modo_hex=1 -> digit 0 = 0001110, digit 1 = 0001000.
- Shadow=0x0070, apagar_zeros=1 -> digits 3 and 2 show saida=1111111 with anodes still scanning; digit 1 = 1111000; digit 0 = 1000000. Shadow=0x0000 -> only digit 0 shows 1000000.
- habilita dropped for 10 cycles mid-slot -> outputs off within 1 edge. When restored, the same digit resumes with the remaining slot cycles.
- entrada changed without carregar -> saida unchanged. carregar pulse while index is on the changed digit -> new pattern visible on the next edge.
- Async reset asserted between edges mid-scan -> saida=1111111 and anodo=1111 without waiting for a clock edge. After release, scan restarts at digit 0 with shadow=0.
- ATIVO_BAIXO=0 build, shadow=0x0008 -> digit 0 slot: anodo=0001, saida=1111111; guard cycles have anodo=0000, saida=0000000.
